// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg
// Shared widths, the NOP encoding and the memory-controller state encoding.
// The IMEM_ST_* states are kept here so the data-memory controller can reuse
// the same 2-bit encoding.
package imem_fetch_ctrl_pkg;

    localparam int WORD_ADDR_W = 32;
    localparam int WORD_DATA_W = 32;
    // Word tag: byte address without the two offset bits.
    localparam int TAG_W       = WORD_ADDR_W - 2;

    // Instruction substituted on a miss, flush, misalignment or bus timeout.
    localparam logic [WORD_DATA_W-1:0] INS_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_ST_IDLE = 2'b00,
        IMEM_ST_REQ  = 2'b01,
        IMEM_ST_WAIT = 2'b10
    } imem_st_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if
// Instruction-bus read port.
//   bus_req     : request, held until read data or timeout (master -> slave)
//   bus_addr    : word-aligned read address, stable while bus_req is high
//   bus_grnt    : bus granted to this master (slave -> master)
//   bus_rdy     : read data valid this cycle (slave -> master)
//   bus_rd_data : read data (slave -> master)
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic                   bus_req;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic                   bus_grnt;
    logic                   bus_rdy;
    logic [WORD_DATA_W-1:0] bus_rd_data;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_grnt,
        input  bus_rdy,
        input  bus_rd_data
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_grnt,
        output bus_rdy,
        output bus_rd_data
    );

endinterface

// File: rtl/imem_fetch_ctrl_buf.sv
// if_fetch_buf
// One-entry fetch buffer: tag/data/error register with hit compare.
//   clk, rst : clock, active-low asynchronous reset
//   inv      : invalidate; wins over a simultaneous write
//   we       : write {wtag, wdata, werr}
//   rtag     : lookup tag from the fetch address
//   hit      : entry valid and tag matches rtag
//   rdata    : stored instruction word
//   rerr     : stored word is a timeout substitute
module if_fetch_buf
    import imem_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inv,
    input  logic                   we,
    input  logic [TAG_W-1:0]       wtag,
    input  logic [WORD_DATA_W-1:0] wdata,
    input  logic                   werr,
    input  logic [TAG_W-1:0]       rtag,
    output logic                   hit,
    output logic [WORD_DATA_W-1:0] rdata,
    output logic                   rerr
);

    logic                   valid_r;
    logic [TAG_W-1:0]       tag_r;
    logic [WORD_DATA_W-1:0] data_r;
    logic                   err_r;

    // Entry storage; invalidate has priority over a write on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            tag_r   <= {TAG_W{1'b0}};
            data_r  <= INS_NOP;
            err_r   <= 1'b0;
        end else begin
            if (inv) begin
                valid_r <= 1'b0;
            end else if (we) begin
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
            if (we) begin
                tag_r  <= wtag;
                data_r <= wdata;
                err_r  <= werr;
            end
        end
    end

    assign hit   = valid_r & (tag_r == rtag);
    assign rdata = data_r;
    assign rerr  = err_r;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-memory responder for the fetch stage. Serves hits from a
// one-entry buffer combinationally; on a miss it stalls and reads the word
// over the instruction bus, with flush-safe discard and a WAIT timeout.
//   clk, rst       : clock, active-low asynchronous reset
//   if_pc, if_en   : fetch address / request from the IF register
//   flush          : pipeline redirect
//   inv            : invalidate the fetch buffer
//   insn           : instruction to the IF register
//   stall          : fetch not satisfied this cycle
//   fetch_err      : insn is a NOP substituted after a bus timeout
//   fetch_misalign : if_pc not word aligned with if_en high
//   bus            : instruction bus master port
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_ADDR_W-1:0] if_pc,
    input  logic                   if_en,
    input  logic                   flush,
    input  logic                   inv,
    output logic [WORD_DATA_W-1:0] insn,
    output logic                   stall,
    output logic                   fetch_err,
    output logic                   fetch_misalign,
    imem_fetch_ctrl_if.master      bus
);

    // Value of the counter during the last WAIT cycle before timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    imem_st_e         state_r;
    logic             drop_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bus_req_r;
    logic [TAG_W-1:0] bus_tag_r;

    logic                   aligned_s;
    logic                   buf_hit_s;
    logic                   hit_s;
    logic                   miss_s;
    logic                   timeout_s;
    logic                   buf_we_s;
    logic [WORD_DATA_W-1:0] buf_wdata_s;
    logic                   buf_werr_s;
    logic [WORD_DATA_W-1:0] buf_data_s;
    logic                   buf_err_s;

    assign aligned_s    = (if_pc[1:0] == 2'b00);
    assign hit_s        = if_en & aligned_s & buf_hit_s;
    assign miss_s       = if_en & aligned_s & ~buf_hit_s;
    assign timeout_s    = (state_r == IMEM_ST_WAIT) & ~bus.bus_rdy & (cnt_r == CNT_LAST);
    assign bus.bus_req  = bus_req_r;
    assign bus.bus_addr = {bus_tag_r, 2'b00};

    if_fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .inv   (inv),
        .we    (buf_we_s),
        .wtag  (bus_tag_r),
        .wdata (buf_wdata_s),
        .werr  (buf_werr_s),
        .rtag  (if_pc[WORD_ADDR_W-1:2]),
        .hit   (buf_hit_s),
        .rdata (buf_data_s),
        .rerr  (buf_err_s)
    );

    // Buffer fill at the end of WAIT; a flush on the completing cycle discards too.
    always_comb begin
        buf_we_s    = 1'b0;
        buf_wdata_s = INS_NOP;
        buf_werr_s  = 1'b0;
        if ((state_r == IMEM_ST_WAIT) && !drop_r && !flush) begin
            if (bus.bus_rdy) begin
                buf_we_s    = 1'b1;
                buf_wdata_s = bus.bus_rd_data;
                buf_werr_s  = 1'b0;
            end else if (timeout_s) begin
                buf_we_s    = 1'b1;
                buf_wdata_s = INS_NOP;
                buf_werr_s  = 1'b1;
            end else begin
                buf_we_s    = 1'b0;
            end
        end else begin
            buf_we_s = 1'b0;
        end
    end

    // Fetch-side outputs; flush overrides everything so the redirect is accepted.
    always_comb begin
        insn           = INS_NOP;
        stall          = 1'b0;
        fetch_err      = 1'b0;
        fetch_misalign = if_en & ~aligned_s;
        if (flush) begin
            insn  = INS_NOP;
            stall = 1'b0;
        end else if (hit_s) begin
            insn      = buf_data_s;
            fetch_err = buf_err_s;
        end else if (miss_s) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Bus transaction FSM with drop flag and saturating WAIT counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IMEM_ST_IDLE;
            drop_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            bus_req_r <= 1'b0;
            bus_tag_r <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                IMEM_ST_IDLE: begin
                    // A miss seen together with a flush belongs to the
                    // discarded PC, so no access is started for it.
                    if (miss_s && !flush) begin
                        state_r   <= IMEM_ST_REQ;
                        bus_req_r <= 1'b1;
                        bus_tag_r <= if_pc[WORD_ADDR_W-1:2];
                        drop_r    <= 1'b0;
                    end else begin
                        state_r   <= IMEM_ST_IDLE;
                    end
                end
                IMEM_ST_REQ: begin
                    if (flush) begin
                        state_r   <= IMEM_ST_IDLE;
                        bus_req_r <= 1'b0;
                    end else if (bus.bus_grnt) begin
                        state_r <= IMEM_ST_WAIT;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= IMEM_ST_REQ;
                    end
                end
                IMEM_ST_WAIT: begin
                    if (flush) begin
                        drop_r <= 1'b1;
                    end
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    if (bus.bus_rdy || timeout_s) begin
                        state_r   <= IMEM_ST_IDLE;
                        bus_req_r <= 1'b0;
                    end else begin
                        state_r <= IMEM_ST_WAIT;
                    end
                end
                default: begin
                    state_r   <= IMEM_ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Self-checking bench: directed scenarios plus randomized fetch traffic,
// checked against a one-entry buffer model and the miss-latency rule
// (stall cycles = 3 + grant wait + ready wait).
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        if_en = 1'b0;
    logic        flush = 1'b0;
    logic        inv = 1'b0;
    logic [31:0] insn;
    logic        stall;
    logic        fetch_err;
    logic        fetch_misalign;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_en          (if_en),
        .flush          (flush),
        .inv            (inv),
        .insn           (insn),
        .stall          (stall),
        .fetch_err      (fetch_err),
        .fetch_misalign (fetch_misalign),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the single buffer entry.
    bit          mv = 1'b0;
    logic [29:0] mtag = 30'h0;
    logic [31:0] mdata = 32'h0;
    bit          merr = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch of pc; on a miss the bench acts as bus slave with the given waits.
    task automatic do_fetch(input logic [31:0] pc, input int gd, input int rd, input logic [31:0] data);
        bit exp_hit;
        int c;
        int stalls;
        bit done;
        step();
        if_pc = pc; if_en = 1'b1; flush = 1'b0; inv = 1'b0;
        bus.bus_grnt = 1'b0; bus.bus_rdy = 1'b0;
        exp_hit = mv && (mtag == pc[31:2]);
        @(negedge clk);
        n_checks++;
        if (fetch_misalign !== 1'b0) begin n_errors++; $display("FAIL fetch_misalign pc=%h got %b exp 0", pc, fetch_misalign); end
        if (exp_hit) begin
            n_checks++;
            if (stall !== 1'b0) begin n_errors++; $display("FAIL hit_stall pc=%h got %b exp 0", pc, stall); end
            n_checks++;
            if (insn !== mdata) begin n_errors++; $display("FAIL hit_insn pc=%h got %h exp %h", pc, insn, mdata); end
            n_checks++;
            if (fetch_err !== merr) begin n_errors++; $display("FAIL hit_err pc=%h got %b exp %b", pc, fetch_err, merr); end
        end else begin
            n_checks++;
            if (bus.bus_req !== 1'b0) begin n_errors++; $display("FAIL miss_start_idle pc=%h bus_req got %b exp 0", pc, bus.bus_req); end
            c = 0; stalls = 0; done = 1'b0;
            while (!done && c < 60) begin
                if (stall === 1'b1) begin
                    stalls++;
                    if (c > 0) begin
                        n_checks++;
                        if (bus.bus_req !== 1'b1 || bus.bus_addr !== {pc[31:2], 2'b00}) begin
                            n_errors++;
                            $display("FAIL miss_bus c=%0d got req=%b addr=%h exp req=1 addr=%h", c, bus.bus_req, bus.bus_addr, {pc[31:2], 2'b00});
                        end
                    end
                    step();
                    c++;
                    bus.bus_grnt = (c == 1 + gd);
                    bus.bus_rdy = (c == 2 + gd + rd);
                    bus.bus_rd_data = bus.bus_rdy ? data : $urandom;
                    @(negedge clk);
                end else begin
                    done = 1'b1;
                end
            end
            n_checks++;
            if (!done) begin n_errors++; $display("FAIL miss_bound pc=%h stall never released after %0d cycles", pc, c); end
            n_checks++;
            if (stalls !== 3 + gd + rd) begin n_errors++; $display("FAIL miss_latency pc=%h got %0d exp %0d", pc, stalls, 3 + gd + rd); end
            n_checks++;
            if (insn !== data || fetch_err !== 1'b0) begin
                n_errors++; $display("FAIL miss_insn pc=%h got %h/%b exp %h/0", pc, insn, fetch_err, data);
            end
            mv = 1'b1; mtag = pc[31:2]; mdata = data; merr = 1'b0;
        end
        bus.bus_grnt = 1'b0; bus.bus_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_en = 1'b0; flush = 1'b0; inv = 1'b0; if_pc = 32'h0;
        bus.bus_grnt = 1'b0; bus.bus_rdy = 1'b0; bus.bus_rd_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (insn !== INS_NOP || stall !== 1'b0) begin n_errors++; $display("FAIL reset_out got insn=%h stall=%b exp %h/0", insn, stall, INS_NOP); end
        n_checks++;
        if (fetch_err !== 1'b0 || fetch_misalign !== 1'b0) begin n_errors++; $display("FAIL reset_flags got err=%b mis=%b exp 0/0", fetch_err, fetch_misalign); end
        n_checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_addr !== 32'h0) begin n_errors++; $display("FAIL reset_bus got req=%b addr=%h exp 0/0", bus.bus_req, bus.bus_addr); end
        mv = 1'b0;
    endtask

    task automatic test_cold_fetch();
        do_fetch(32'h0000_0100, 0, 0, 32'h1234_5678);
        do_fetch(32'h0000_0100, 0, 0, 32'h0);
    endtask

    task automatic test_misaligned();
        // 0x102 shares its word tag with the buffered 0x100 entry.
        for (int i = 0; i < 4; i++) begin
            step();
            if_pc = 32'h0000_0102; if_en = 1'b1;
            @(negedge clk);
            n_checks++;
            if (fetch_misalign !== 1'b1 || stall !== 1'b0 || insn !== INS_NOP || bus.bus_req !== 1'b0) begin
                n_errors++;
                $display("FAIL misalign got mis=%b stall=%b insn=%h req=%b exp 1/0/%h/0", fetch_misalign, stall, insn, bus.bus_req, INS_NOP);
            end
        end
    endtask

    task automatic test_flush_wait();
        step();
        if_pc = 32'h0000_0200; if_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_miss got %b exp 1", stall); end
        step();
        bus.bus_grnt = 1'b1;
        step();
        bus.bus_grnt = 1'b0; flush = 1'b1; if_pc = 32'h0000_0300;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || insn !== INS_NOP) begin n_errors++; $display("FAIL flush_cycle got stall=%b insn=%h exp 0/%h", stall, insn, INS_NOP); end
        step();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h0000_0200) begin
            n_errors++; $display("FAIL flush_busy got stall=%b req=%b addr=%h exp 1/1/00000200", stall, bus.bus_req, bus.bus_addr);
        end
        step();
        bus.bus_rdy = 1'b1; bus.bus_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_rdy_stall got %b exp 1", stall); end
        // Dropped 0x200 data must not be served; then the redirected PC.
        do_fetch(32'h0000_0200, 0, 1, 32'hCAFE_0200);
        do_fetch(32'h0000_0300, 1, 1, 32'h0BAD_0300);
    endtask

    task automatic test_timeout();
        step();
        if_pc = 32'h0000_0500; if_en = 1'b1;
        step();
        bus.bus_grnt = 1'b1;
        for (int w = 0; w < TO; w++) begin
            step();
            bus.bus_grnt = 1'b0;
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b1 || bus.bus_req !== 1'b1) begin n_errors++; $display("FAIL timeout_wait w=%0d got stall=%b req=%b exp 1/1", w, stall, bus.bus_req); end
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.bus_req !== 1'b0 || stall !== 1'b0 || insn !== INS_NOP || fetch_err !== 1'b1) begin
            n_errors++; $display("FAIL timeout_done got req=%b stall=%b insn=%h err=%b exp 0/0/%h/1", bus.bus_req, stall, insn, fetch_err, INS_NOP);
        end
        mv = 1'b1; mtag = 30'h0000_0500 >> 2; mdata = INS_NOP; merr = 1'b1;
        do_fetch(32'h0000_0500, 0, 0, 32'h0);
    endtask

    task automatic test_invalidate();
        step();
        if_pc = 32'h0000_0600; if_en = 1'b1;
        step();
        bus.bus_grnt = 1'b1;
        step();
        bus.bus_grnt = 1'b0; bus.bus_rdy = 1'b1; inv = 1'b1; bus.bus_rd_data = 32'h6666_0001;
        mv = 1'b0;
        do_fetch(32'h0000_0600, 0, 0, 32'h6666_0002);
        do_fetch(32'h0000_0600, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_0400; pcs[1] = 32'h0000_0404; pcs[2] = 32'h0000_0408; pcs[3] = 32'h0000_1000;
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0 || r == 1) begin
                step();
                if_en = 1'b0; inv = (r == 0);
                @(negedge clk);
                n_checks++;
                if (insn !== INS_NOP || stall !== 1'b0 || bus.bus_req !== 1'b0) begin
                    n_errors++; $display("FAIL idle_cycle got insn=%h stall=%b req=%b exp %h/0/0", insn, stall, bus.bus_req, INS_NOP);
                end
                if (r == 0) mv = 1'b0;
            end else begin
                do_fetch(pcs[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        if_pc = 32'h0000_0700; if_en = 1'b1; inv = 1'b0;
        step();
        bus.bus_grnt = 1'b1;
        step();
        bus.bus_grnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b0) begin n_errors++; $display("FAIL reset_mid_req got %b exp 0", bus.bus_req); end
        mv = 1'b0;
        if_en = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        do_fetch(32'h0000_0700, 0, 0, 32'h7777_0700);
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_misaligned();
        test_flush_wait();
        test_timeout();
        test_invalidate();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
